// File: rtl/crc_tx_pkg.sv
// Shared types and defaults for the CRC-8 serial frame sequencer.
// Build option: CRC_TX_PREAMBLE_EN (used by crc_tx_sequencer).
package crc_tx_pkg;

    localparam int         CRC_WIDTH_DEF = 8;
    localparam logic [7:0] PREAMBLE_DEF  = 8'h7E;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        PRE,
        DATA,
        GAP,
        CRC
    } state_t;

endpackage

// File: rtl/crc_tx_shifter.sv
// Parallel-in serial-out shift register, LSB first, with bit counter.
// Load takes priority over shift; the counter wraps after the top bit.
module crc_tx_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  bit_o,
    output logic                  first_o,
    output logic                  last_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CW-1:0]         cnt_q;

    assign bit_o   = shreg_q[0];
    assign first_o = (cnt_q == '0);
    assign last_o  = (cnt_q == CW'(DATA_WIDTH - 1));

    // Word register and bit position within the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
            cnt_q   <= '0;
        end else if (shift_i) begin
            shreg_q <= shreg_q >> 1;
            cnt_q   <= last_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/crc_tx_sequencer.sv
// Frame sequencer feeding a serial CRC-8 engine and emitting the framed bits.
// Build option: CRC_TX_PREAMBLE_EN replaces the reseed cycle with a preamble.
module crc_tx_sequencer
    import crc_tx_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CRC_WIDTH  = CRC_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE   = DATA_WIDTH'(PREAMBLE_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  crc_seed_n,
    output logic                  crc_data,
    output logic                  crc_active,
    input  logic                  crc_bit,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  ser_sof,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  busy
);

`ifdef CRC_TX_PREAMBLE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    localparam int MAXW  = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
    localparam int CNT_W = $clog2(MAXW);
    localparam int DBW   = $clog2(DATA_WIDTH);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seed_n_q, seed_n_d;

    logic sh_load, sh_shift, sh_bit, sh_first, sh_last;

    crc_tx_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  (s_data),
        .bit_o   (sh_bit),
        .first_o (sh_first),
        .last_o  (sh_last)
    );

    assign crc_seed_n = seed_n_q;
    assign busy       = (state_q != IDLE);

    // State, frame flags, phase counter and the registered reseed strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b0;
            first_q  <= 1'b0;
            cnt_q    <= '0;
            seed_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
            seed_n_q <= seed_n_d;
        end
    end

    // Next-state and output decode; the engine cannot stall, so a missing
    // word at the end of a non-last word aborts the frame.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        first_d    = first_q;
        cnt_d      = cnt_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        s_ready    = 1'b0;
        crc_data   = 1'b0;
        crc_active = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        ser_sof    = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    sh_load = 1'b1;
                    last_d  = s_last;
                    first_d = !PRE_EN;
                    cnt_d   = '0;
                    state_d = PRE_EN ? PRE : SEED;
                end
            end
            SEED: begin
                state_d = DATA;
            end
            PRE: begin
                ser_out   = PREAMBLE[cnt_q[DBW-1:0]];
                ser_valid = 1'b1;
                ser_sof   = (cnt_q == '0);
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                crc_active = 1'b1;
                crc_data   = sh_bit;
                ser_out    = sh_bit;
                ser_valid  = 1'b1;
                ser_sof    = first_q & sh_first;
                sh_shift   = 1'b1;
                first_d    = 1'b0;
                if (sh_last) begin
                    if (last_q) begin
                        state_d = GAP;
                    end else begin
                        s_ready = 1'b1;
                        if (s_valid) begin
                            sh_load = 1'b1;
                            last_d  = s_last;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                cnt_d   = '0;
                state_d = CRC;
            end
            CRC: begin
                ser_out   = crc_bit;
                ser_valid = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CRC_WIDTH - 1)) begin
                    frame_done = 1'b1;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        seed_n_d = !((state_d == SEED) || (state_d == PRE));
    end

endmodule

// File: tb/tb_crc_tx_sequencer.sv
// Randomised bench for crc_tx_sequencer with a serial CRC-8 engine model.
// Build option: CRC_TX_PREAMBLE_EN selects the preamble framing checks.
module tb_crc_tx_sequencer;

`ifdef CRC_TX_PREAMBLE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    localparam logic [7:0] PRE_PAT = 8'h7E;
    localparam logic [7:0] SEEDV   = 8'hD8;
    localparam logic [7:0] POLY_R  = 8'hE0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, crc_seed_n, crc_data, crc_active, crc_bit;
    logic       ser_out, ser_valid, ser_sof, frame_done, frame_err, busy;

    always #5 clk = ~clk;

    crc_tx_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .crc_seed_n (crc_seed_n),
        .crc_data   (crc_data),
        .crc_active (crc_active),
        .crc_bit    (crc_bit),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_sof    (ser_sof),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // Serial CRC-8 engine: reseeds while its reset pin is low, absorbs
    // LSB-first while active, otherwise shifts its register out.
    wire        eng_rst_n = rst_n & crc_seed_n;
    logic [7:0] eng_q;
    always @(posedge clk or negedge eng_rst_n) begin
        if (!eng_rst_n) begin
            eng_q   <= SEEDV;
            crc_bit <= 1'b0;
        end else if (crc_active) begin
            eng_q <= (eng_q >> 1) ^ ((eng_q[0] ^ crc_data) ? POLY_R : 8'h00);
        end else begin
            crc_bit <= eng_q[0];
            eng_q   <= eng_q >> 1;
        end
    end

    typedef struct packed {
        logic ready, seed_n, active, data, valid;
        logic sout, sof, done, err, busy;
    } obs_t;

    obs_t       q[$];
    obs_t       a_obs, e_obs;
    logic       cap[$];
    int         errors = 0;
    int         checks = 0;
    int         act_cnt, err_cnt, done_at, pop_n;
    logic [7:0] w[8];
    int         n, ur;

    function automatic logic [7:0] crc_of(input logic [7:0] ws[8], input int cnt);
        logic [7:0] c = SEEDV;
        for (int i = 0; i < cnt; i++) begin
            c ^= ws[i];
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
        end
        return c;
    endfunction

    function automatic obs_t idle_obs();
        obs_t r = '0;
        r.ready  = 1'b1;
        r.seed_n = 1'b1;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t r;
        r.ready  = s_ready;
        r.seed_n = crc_seed_n;
        r.active = crc_active;
        r.data   = crc_active ? crc_data : 1'b0;
        r.valid  = ser_valid;
        r.sout   = ser_valid ? ser_out : 1'b0;
        r.sof    = ser_sof;
        r.done   = frame_done;
        r.err    = frame_err;
        r.busy   = busy;
        return r;
    endfunction

    function automatic logic [7:0] cap_byte(input int off);
        logic [7:0] b = '0;
        for (int k = 0; k < 8; k++)
            if (off + k < cap.size()) b[k] = cap[off + k];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected cycle-by-cycle trace of one frame, from the framing rules.
    task automatic push_frame();
        obs_t o;
        int   nsent = (ur > 0) ? ur : n;
        logic [7:0] c = crc_of(w, n);
        if (PRE_EN) begin
            for (int j = 0; j < 8; j++) begin
                o = '0; o.valid = 1'b1; o.sout = PRE_PAT[j];
                o.sof = (j == 0); o.busy = 1'b1;
                q.push_back(o);
            end
        end else begin
            o = '0; o.busy = 1'b1;
            q.push_back(o);
        end
        for (int i = 0; i < nsent; i++) begin
            for (int j = 0; j < 8; j++) begin
                o = '0; o.seed_n = 1'b1; o.active = 1'b1; o.busy = 1'b1;
                o.data = w[i][j]; o.valid = 1'b1; o.sout = w[i][j];
                o.sof = !PRE_EN && i == 0 && j == 0;
                if (j == 7 && i < nsent - 1) o.ready = 1'b1;
                if (j == 7 && ur > 0 && i == nsent - 1) begin
                    o.ready = 1'b1; o.err = 1'b1;
                end
                q.push_back(o);
            end
        end
        if (ur == 0) begin
            o = '0; o.seed_n = 1'b1; o.busy = 1'b1;
            q.push_back(o);
            for (int k = 0; k < 8; k++) begin
                o = '0; o.seed_n = 1'b1; o.busy = 1'b1; o.valid = 1'b1;
                o.sout = c[k]; o.done = (k == 7);
                q.push_back(o);
            end
        end
    endtask

    // One compare per cycle against the expected trace or the idle state.
    always @(negedge clk) begin
        a_obs = sample();
        if (!rst_n) begin
            e_obs = idle_obs();
        end else if (q.size() > 0) begin
            e_obs = q.pop_front();
            pop_n++;
            if (a_obs.valid) cap.push_back(a_obs.sout);
            if (a_obs.active) act_cnt++;
            if (a_obs.err) err_cnt++;
            if (a_obs.done) done_at = pop_n;
        end else begin
            e_obs = idle_obs();
        end
        check("cycle", 32'(a_obs), 32'(e_obs));
    end

    task automatic clear_cap();
        cap.delete();
        act_cnt = 0; err_cnt = 0; done_at = 0; pop_n = 0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk); #1;
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit done_ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (q.size() == 0) begin
                done_ok = 1'b1;
                break;
            end
        end
        if (!done_ok) check("drain_timeout", 0, 1);
    endtask

    task automatic run_frame();
        bit ok;
        int nsent = (ur > 0) ? ur : n;
        @(posedge clk); #1;
        s_data = w[0]; s_last = (nsent == n) && (n == 1); s_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin s_valid = 1'b0; return; end
        push_frame();
        for (int i = 1; i < nsent; i++) begin
            s_data = w[i]; s_last = (i == n - 1);
            wait_ready(ok);
            if (!ok) break;
        end
        s_valid = 1'b0; s_last = 1'b0;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [7:0] exp_crc;
        int off;
        clear_cap();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (5) @(negedge clk);
        #1;
        check("rst_ready", s_ready, 1);
        check("rst_seed_n", crc_seed_n, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", ser_valid, 0);
        check("rst_active", crc_active, 0);

        w[0] = 8'hA5;
        check("model_a5", crc_of(w, 1), 8'hCC);
        w[0] = 8'h00;
        check("model_00", crc_of(w, 1), 8'h82);

        off = PRE_EN ? 8 : 0;

        clear_cap();
        w[0] = 8'hA5; n = 1; ur = 0;
        run_frame();
        check("a5_len", cap.size(), off + 16);
        check("a5_data", cap_byte(off), 8'hA5);
        check("a5_crc", cap_byte(off + 8), 8'hCC);
        check("a5_done_lat", done_at, PRE_EN ? 25 : 18);

        clear_cap();
        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03; n = 3; ur = 0;
        run_frame();
        check("multi_active", act_cnt, 24);
        exp_crc = crc_of(w, 3);
        check("multi_crc", cap_byte(off + 24), exp_crc);

        clear_cap();
        w[0] = 8'h3C; w[1] = 8'hC3; n = 2; ur = 1;
        run_frame();
        check("under_err", err_cnt, 1);
        check("under_len", cap.size(), off + 8);

        clear_cap();
        w[0] = 8'hE7; n = 1; ur = 0;
        @(posedge clk); #1;
        s_data = w[0]; s_last = 1'b1; s_valid = 1'b1;
        wait_ready(ok);
        s_valid = 1'b0; s_last = 1'b0;
        push_frame();
        repeat ((PRE_EN ? 8 : 1) + 8 + 1 + 4) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("mid_busy", busy, 0);
        check("mid_valid", ser_valid, 0);
        check("mid_seed_n", crc_seed_n, 1);
        check("mid_active", crc_active, 0);
        check("mid_done", frame_done, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        clear_cap();
        w[0] = 8'h5A; n = 1; ur = 0;
        run_frame();
        exp_crc = crc_of(w, 1);
        check("post_rst_crc", cap_byte(off + 8), exp_crc);

        clear_cap();
        w[0] = 8'h00; n = 1; ur = 0;
        run_frame();
        check("zero_crc", cap_byte(off + 8), 8'h82);
        if (PRE_EN) check("zero_pre", cap_byte(0), PRE_PAT);

        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
            ur = (n > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : 0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_frame();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
